// File: rtl/pcm_buf_pkg.sv
// Shared definitions for the PCM output ping-pong buffer controller.
package pcm_buf_pkg;

    // Default sample width and RAM address width (1024x16 RAM).
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;

    // Reader FSM: IDLE waits for a full bank, PLAY serves requests from it.
    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } rd_state_t;

    // Sample value returned to the AC97 side when no data is available.
    localparam int SILENCE = 0;

endpackage

// File: rtl/pcm_bank_ptr.sv
// Bank/pointer counter for one side of the ping-pong buffer. The pointer
// walks through a half of the RAM; stepping past its last entry wraps it,
// toggles the bank and raises a one-cycle wrap pulse used to set or clear
// that bank's full flag.
module pcm_bank_ptr
    import pcm_buf_pkg::*;
#(
    parameter int PTR_WIDTH = ADDR_WIDTH_DEF - 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 flush,
    input  logic                 advance,
    output logic                 bank,
    output logic [PTR_WIDTH-1:0] ptr,
    output logic                 wrap
);

    assign wrap = advance && (ptr == '1);

    // Step the pointer on each access; on the last entry move to the other bank.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bank <= 1'b0;
            ptr  <= '0;
        end else if (flush) begin
            bank <= 1'b0;
            ptr  <= '0;
        end else if (advance) begin
            if (wrap) begin
                bank <= ~bank;
                ptr  <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcm_buf_ctrl.sv
// Ping-pong scheduler for the PCM output dual-port RAM. The MAC writes one
// bank through port A while the AC97 side drains the other through port B.
// Requests against a non-full bank are answered with silence and flagged
// as underrun.
module pcm_buf_ctrl
    import pcm_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  FLUSH,
    input  logic                  PCM_VALID,
    input  logic [DATA_WIDTH-1:0] PCM_DATA,
    output logic                  PCM_READY,
    input  logic                  SAMPLE_REQ,
    output logic [DATA_WIDTH-1:0] SAMPLE_DATA,
    output logic                  SAMPLE_VALID,
    output logic                  UNDERRUN,
    output logic [ADDR_WIDTH:0]   FILL_LEVEL,
    output logic [1:0]            BANK_FULL,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRA,
    output logic [DATA_WIDTH-1:0] RAM_DIA,
    output logic                  RAM_ENA,
    output logic                  RAM_WEA,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRB,
    output logic                  RAM_ENB,
    input  logic [DATA_WIDTH-1:0] RAM_DOB
);

    localparam int PTR_WIDTH = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH:0] FILL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic                  wbank, rbank;
    logic [PTR_WIDTH-1:0]  wptr, rptr;
    logic                  w_wrap, r_wrap;
    logic [1:0]            bank_full, bank_full_next;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  wr_fire, req_acc, rd_hit, rd_miss;
    logic                  rd_pend, rd_pend_und;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    rd_state_t             state, state_next;

    // Writer side: accept only into a non-full bank, and never during a flush.
    // Reset also forces READY low so that every output is quiet while held.
    assign PCM_READY = RST_N && !bank_full[wbank] && !FLUSH;
    assign wr_fire   = PCM_VALID && PCM_READY;
    assign RAM_ENA   = wr_fire;
    assign RAM_WEA   = wr_fire;
    assign RAM_ADDRA = wr_fire ? {wbank, wptr} : '0;
    assign RAM_DIA   = wr_fire ? PCM_DATA : '0;

    // A new request is taken only when no earlier response is still in flight.
    assign req_acc = SAMPLE_REQ && !rd_pend && !FLUSH;

    // Port B is enabled in the request cycle and held for the data cycle.
    assign RAM_ENB   = rd_hit || (rd_pend && !rd_pend_und);
    assign RAM_ADDRB = rd_hit ? {rbank, rptr} :
                       (rd_pend && !rd_pend_und) ? rd_addr_q : '0;

    assign BANK_FULL  = bank_full;
    assign FILL_LEVEL = fill_level;

    pcm_bank_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .flush   (FLUSH),
        .advance (wr_fire),
        .bank    (wbank),
        .ptr     (wptr),
        .wrap    (w_wrap)
    );

    pcm_bank_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .flush   (FLUSH),
        .advance (rd_hit),
        .bank    (rbank),
        .ptr     (rptr),
        .wrap    (r_wrap)
    );

    // Reader FSM next state and request classification (real read vs underrun).
    always_comb begin
        state_next = state;
        rd_hit     = 1'b0;
        rd_miss    = 1'b0;
        case (state)
            IDLE: begin
                if (req_acc) begin
                    if (bank_full[rbank]) rd_hit = 1'b1;
                    else                  rd_miss = 1'b1;
                end
                if (bank_full[rbank]) state_next = PLAY;
            end
            PLAY: begin
                if (req_acc) begin
                    if (bank_full[rbank]) begin
                        rd_hit = 1'b1;
                    end else begin
                        rd_miss    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reader FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     state <= IDLE;
        else if (FLUSH) state <= IDLE;
        else            state <= state_next;
    end

    // Full flags: the reader frees its bank and the writer claims its bank.
    always_comb begin
        bank_full_next = bank_full;
        if (r_wrap) bank_full_next[rbank] = 1'b0;
        if (w_wrap) bank_full_next[wbank] = 1'b1;
    end

    // Full flag register; both sides' updates land in the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     bank_full <= 2'b00;
        else if (FLUSH) bank_full <= 2'b00;
        else            bank_full <= bank_full_next;
    end

    // Occupancy: up on a write, down on a real read, saturating at both ends.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fill_level <= '0;
        end else if (FLUSH) begin
            fill_level <= '0;
        end else if (wr_fire && !rd_hit && fill_level != FILL_MAX) begin
            fill_level <= fill_level + 1'b1;
        end else if (rd_hit && !wr_fire && fill_level != '0) begin
            fill_level <= fill_level - 1'b1;
        end
    end

    // Response pipeline: remember the outstanding request, then return either
    // the RAM word or silence. A flush does not cancel a response in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_pend      <= 1'b0;
            rd_pend_und  <= 1'b0;
            rd_addr_q    <= '0;
            SAMPLE_DATA  <= '0;
            SAMPLE_VALID <= 1'b0;
            UNDERRUN     <= 1'b0;
        end else begin
            rd_pend      <= rd_hit || rd_miss;
            rd_pend_und  <= rd_miss;
            if (rd_hit) rd_addr_q <= {rbank, rptr};
            SAMPLE_VALID <= rd_pend;
            UNDERRUN     <= rd_pend && rd_pend_und;
            if (rd_pend) SAMPLE_DATA <= rd_pend_und ? DATA_WIDTH'(SILENCE) : RAM_DOB;
        end
    end

endmodule

// File: tb/tb_pcm_buf_ctrl.sv
// Testbench for pcm_buf_ctrl with a small RAM (16 words, 8 per bank).
// The reference model treats the buffer as a stream: W samples written and
// R samples read since the last restart, with whole banks W/8 and R/8.
module tb_pcm_buf_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int HALF  = 8;
    localparam int DEPTH = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          und;
        int            cyc;
    } resp_t;

    logic          CLK;
    logic          RST_N;
    logic          FLUSH;
    logic          PCM_VALID;
    logic [DW-1:0] PCM_DATA;
    logic          PCM_READY;
    logic          SAMPLE_REQ;
    logic [DW-1:0] SAMPLE_DATA;
    logic          SAMPLE_VALID;
    logic          UNDERRUN;
    logic [AW:0]   FILL_LEVEL;
    logic [1:0]    BANK_FULL;
    logic [AW-1:0] RAM_ADDRA;
    logic [DW-1:0] RAM_DIA;
    logic          RAM_ENA;
    logic          RAM_WEA;
    logic [AW-1:0] RAM_ADDRB;
    logic          RAM_ENB;
    logic [DW-1:0] RAM_DOB;

    logic [DW-1:0] ram [0:DEPTH-1];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int            w_cnt    = 0;
    int            r_cnt    = 0;
    logic [DW-1:0] stream[$];
    logic          last_acc = 1'b0;
    logic          last_hit = 1'b0;
    resp_t         sb_q[$];

    pcm_buf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .FLUSH        (FLUSH),
        .PCM_VALID    (PCM_VALID),
        .PCM_DATA     (PCM_DATA),
        .PCM_READY    (PCM_READY),
        .SAMPLE_REQ   (SAMPLE_REQ),
        .SAMPLE_DATA  (SAMPLE_DATA),
        .SAMPLE_VALID (SAMPLE_VALID),
        .UNDERRUN     (UNDERRUN),
        .FILL_LEVEL   (FILL_LEVEL),
        .BANK_FULL    (BANK_FULL),
        .RAM_ADDRA    (RAM_ADDRA),
        .RAM_DIA      (RAM_DIA),
        .RAM_ENA      (RAM_ENA),
        .RAM_WEA      (RAM_WEA),
        .RAM_ADDRB    (RAM_ADDRB),
        .RAM_ENB      (RAM_ENB),
        .RAM_DOB      (RAM_DOB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Dual-port RAM: synchronous write on A, registered read on B.
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) ram[RAM_ADDRA] <= RAM_DIA;
        if (RAM_ENB) RAM_DOB <= ram[RAM_ADDRB];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Full banks are the stream banks R/8 .. W/8-1; bank k lives in RAM half k%2.
    function automatic logic [1:0] expBankFull();
        logic [1:0] f;
        f = 2'b00;
        for (int k = r_cnt / HALF; k < w_cnt / HALF; k++) f[k % 2] = 1'b1;
        return f;
    endfunction

    task automatic modelReset();
        w_cnt = 0;
        r_cnt = 0;
        stream.delete();
        last_acc = 1'b0;
        last_hit = 1'b0;
    endtask

    // One clock cycle of stimulus; checks the combinational and registered
    // status seen in this cycle and queues the expected response of a request.
    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                 input logic req, input logic flush);
        logic exp_ready, wr, acc, hit;
        @(negedge CLK);
        PCM_VALID  = valid;
        PCM_DATA   = data;
        SAMPLE_REQ = req;
        FLUSH      = flush;
        #1;
        exp_ready = !flush && ((w_cnt / HALF - r_cnt / HALF) < 2);
        wr  = valid && exp_ready;
        acc = req && !flush && !last_acc;
        hit = acc && (r_cnt / HALF < w_cnt / HALF);
        checkOutput("PCM_READY", 32'(PCM_READY), 32'(exp_ready));
        checkOutput("FILL_LEVEL", 32'(FILL_LEVEL), 32'(w_cnt - r_cnt));
        checkOutput("BANK_FULL", 32'(BANK_FULL), 32'(expBankFull()));
        checkOutput("RAM_ENA", 32'(RAM_ENA), 32'(wr));
        checkOutput("RAM_WEA", 32'(RAM_WEA), 32'(wr));
        if (wr) begin
            checkOutput("RAM_ADDRA", 32'(RAM_ADDRA), 32'(w_cnt % DEPTH));
            checkOutput("RAM_DIA", 32'(RAM_DIA), 32'(data));
        end
        checkOutput("RAM_ENB", 32'(RAM_ENB), 32'(hit || last_hit));
        if (hit) checkOutput("RAM_ADDRB", 32'(RAM_ADDRB), 32'(r_cnt % DEPTH));
        if (acc) sb_q.push_back('{hit ? stream[r_cnt] : '0, !hit, cyc + 2});
        if (hit) r_cnt++;
        if (wr) begin
            stream.push_back(data);
            w_cnt++;
        end
        if (flush) begin
            w_cnt = 0;
            r_cnt = 0;
            stream.delete();
        end
        last_acc = acc;
        last_hit = hit;
    endtask

    task automatic checkResetOutputs();
        checkOutput("RST_PCM_READY", 32'(PCM_READY), 32'(0));
        checkOutput("RST_SAMPLE_DATA", 32'(SAMPLE_DATA), 32'(0));
        checkOutput("RST_SAMPLE_VALID", 32'(SAMPLE_VALID), 32'(0));
        checkOutput("RST_UNDERRUN", 32'(UNDERRUN), 32'(0));
        checkOutput("RST_FILL_LEVEL", 32'(FILL_LEVEL), 32'(0));
        checkOutput("RST_BANK_FULL", 32'(BANK_FULL), 32'(0));
        checkOutput("RST_RAM_ADDRA", 32'(RAM_ADDRA), 32'(0));
        checkOutput("RST_RAM_DIA", 32'(RAM_DIA), 32'(0));
        checkOutput("RST_RAM_ENA", 32'(RAM_ENA), 32'(0));
        checkOutput("RST_RAM_WEA", 32'(RAM_WEA), 32'(0));
        checkOutput("RST_RAM_ADDRB", 32'(RAM_ADDRB), 32'(0));
        checkOutput("RST_RAM_ENB", 32'(RAM_ENB), 32'(0));
    endtask

    // Asynchronous reset asserted in the middle of a cycle with a write offered.
    task automatic pulseReset();
        @(negedge CLK);
        PCM_VALID  = 1'b1;
        PCM_DATA   = 16'hDEAD;
        SAMPLE_REQ = 1'b0;
        FLUSH      = 1'b0;
        #2 RST_N = 1'b0;
        #1 checkResetOutputs();
        @(negedge CLK);
        @(negedge CLK);
        PCM_VALID = 1'b0;
        RST_N     = 1'b1;
        modelReset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: every SAMPLE_VALID pulse must match the oldest queued response.
    initial begin
        resp_t ex;
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                if (SAMPLE_VALID) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("SAMPLE_VALID_unexpected", 32'(SAMPLE_VALID), 32'(0));
                    end else begin
                        ex = sb_q.pop_front();
                        checkOutput("SAMPLE_LATENCY", 32'(cyc), 32'(ex.cyc));
                        checkOutput("SAMPLE_DATA", 32'(SAMPLE_DATA), 32'(ex.data));
                        checkOutput("UNDERRUN", 32'(UNDERRUN), 32'(ex.und));
                    end
                end else begin
                    if (UNDERRUN) checkOutput("UNDERRUN_stray", 32'(UNDERRUN), 32'(0));
                    if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                        checkOutput("SAMPLE_VALID_missing", 32'(SAMPLE_VALID), 32'(1));
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RST_N      = 1'b0;
        FLUSH      = 1'b0;
        PCM_VALID  = 1'b0;
        PCM_DATA   = '0;
        SAMPLE_REQ = 1'b0;
        #3 checkResetOutputs();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        modelReset();

        $display("[TB] underrun on empty buffer");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(3);

        $display("[TB] fill both banks, then offer a 17th sample");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0110, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0111, 1'b0, 1'b0);

        $display("[TB] drain bank 0 at the slot rate");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
        end
        idle(2);

        $display("[TB] bank 1 completes while bank 0 is released");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 16'(16'h0300 + i), 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 16'h0307, 1'b1, 1'b0);
        idle(3);

        $display("[TB] flush with 11 samples buffered");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0500, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(3);

        $display("[TB] reset in the middle of a write burst");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h0600 + i), 1'b0, 1'b0);
        pulseReset();
        applyStimulus(1'b1, 16'h0700, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            logic v, rq, fl;
            v  = ($urandom_range(0, 99) < (((i / 300) % 2 == 1) ? 80 : 35));
            rq = last_acc ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 70);
            fl = !last_acc && ($urandom_range(0, 299) == 0);
            if (fl) rq = 1'b0;
            applyStimulus(v, 16'($urandom), rq, fl);
        end
        idle(4);
        checkOutput("SCOREBOARD_EMPTY", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
